// File: rtl/line_mem_responder_if.sv
// Line-wide memory bus between the cache controller (master) and the
// backing-store responder (slave). Requests are levels held by the master
// until the matching single-cycle completion pulse.
interface line_mem_responder_if #(
    parameter int LINE_WIDTH = 128
);
    // Read (refill) request channel
    logic                  mem_read;
    logic [31:0]           mem_read_addr;

    // Write (write-back) request channel
    logic                  mem_write;
    logic [31:0]           mem_write_addr;
    logic [LINE_WIDTH-1:0] mem_wr_data;

    // Responses and status
    logic [LINE_WIDTH-1:0] mem_rd_data;
    logic                  mem_rd_data_valid;
    logic                  mem_wr_data_ready;
    logic                  busy;

    // Cache controller side
    modport master (
        output mem_read,
        output mem_read_addr,
        output mem_write,
        output mem_write_addr,
        output mem_wr_data,
        input  mem_rd_data,
        input  mem_rd_data_valid,
        input  mem_wr_data_ready,
        input  busy
    );

    // Memory responder side
    modport slave (
        input  mem_read,
        input  mem_read_addr,
        input  mem_write,
        input  mem_write_addr,
        input  mem_wr_data,
        output mem_rd_data,
        output mem_rd_data_valid,
        output mem_wr_data_ready,
        output busy
    );
endinterface

// File: rtl/line_mem_responder.sv
// Memory-side responder for 128-bit cache lines. Serves one read or write
// at a time from a line-wide block-RAM store after a fixed, parameterised
// latency and answers with one-cycle completion pulses. Writes win over
// reads when both are requested, and a dead cycle after every completion
// keeps a still-held request from being served twice.
module line_mem_responder #(
    parameter int LINE_WIDTH = 128,
    parameter int DEPTH_BITS = 10,
    parameter int RD_LATENCY = 4,   // 1..255
    parameter int WR_LATENCY = 4    // 1..255
) (
    input  logic                  clk,
    input  logic                  rst,
    line_mem_responder_if.slave   bus
);

    localparam int NUM_LINES = 1 << DEPTH_BITS;

    // Counter preloads: the pulse fires on the edge where the count is zero,
    // so latency L needs L-1 further edges after acceptance.
    localparam logic [7:0] RD_LOAD = 8'(RD_LATENCY - 1);
    localparam logic [7:0] WR_LOAD = 8'(WR_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WR_WAIT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                  state_q;
    logic [7:0]              cnt_q;
    logic [DEPTH_BITS-1:0]   idx_q;        // line index of the transaction in flight
    logic [LINE_WIDTH-1:0]   wdata_q;      // write data captured at acceptance
    logic [LINE_WIDTH-1:0]   rd_data_q;
    logic                    rd_valid_q;
    logic                    wr_ready_q;
    logic                    busy_q;

    // Line-wide backing store; deliberately outside the reset domain so
    // contents survive a reset.
    logic [LINE_WIDTH-1:0]   mem_q [NUM_LINES];

    // Line indices decoded from the incoming byte addresses; these become
    // idx_q on acceptance. Byte offset and upper bits are dropped, so the
    // address space wraps modulo the store size.
    logic [DEPTH_BITS-1:0]   rd_idx_d;
    logic [DEPTH_BITS-1:0]   wr_idx_d;
    logic                    wr_fire;
    logic                    unused_addr_bits;

    assign rd_idx_d = bus.mem_read_addr[DEPTH_BITS+3:4];
    assign wr_idx_d = bus.mem_write_addr[DEPTH_BITS+3:4];

    assign unused_addr_bits = ^{bus.mem_read_addr[31:DEPTH_BITS+4],
                                bus.mem_read_addr[3:0],
                                bus.mem_write_addr[31:DEPTH_BITS+4],
                                bus.mem_write_addr[3:0]};

    // Array update happens on the same edge that raises mem_wr_data_ready;
    // a reset on that edge aborts the write.
    assign wr_fire = !rst && (state_q == S_WR_WAIT) && (cnt_q == 8'd0);

    // Store write port: plain synchronous write, no reset, for BRAM inference.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    // Transaction sequencer with registered completion pulses and read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // Pulses default low so each lasts exactly one cycle.
            rd_valid_q <= 1'b0;
            wr_ready_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bus.mem_write) begin
                        // Write-back first: matches the controller's
                        // evict-then-refill ordering.
                        idx_q   <= wr_idx_d;
                        wdata_q <= bus.mem_wr_data;
                        cnt_q   <= WR_LOAD;
                        state_q <= S_WR_WAIT;
                        busy_q  <= 1'b1;
                    end else if (bus.mem_read) begin
                        idx_q   <= rd_idx_d;
                        cnt_q   <= RD_LOAD;
                        state_q <= S_RD_WAIT;
                        busy_q  <= 1'b1;
                    end
                end

                S_RD_WAIT: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        rd_data_q  <= mem_q[idx_q];
                        rd_valid_q <= 1'b1;
                        state_q    <= S_DONE;
                    end
                end

                S_WR_WAIT: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        wr_ready_q <= 1'b1;
                        state_q    <= S_DONE;
                    end
                end

                S_DONE: begin
                    // Dead cycle: a request still held in the pulse cycle is
                    // ignored here and only re-accepted from IDLE.
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_rd_data       = rd_data_q;
    assign bus.mem_rd_data_valid = rd_valid_q;
    assign bus.mem_wr_data_ready = wr_ready_q;
    assign bus.busy              = busy_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Randomised plus directed bench for line_mem_responder. The driver pushes
// expected responses (data and completion cycle) into queues; an independent
// monitor pops and compares on every completion pulse.
module tb_line_mem_responder;

    localparam int LW     = 128;
    localparam int DB     = 10;
    localparam int RL     = 4;
    localparam int WL     = 4;
    localparam int BUDGET = 400;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    line_mem_responder_if #(.LINE_WIDTH(LW)) bus ();

    line_mem_responder #(
        .LINE_WIDTH(LW),
        .DEPTH_BITS(DB),
        .RD_LATENCY(RL),
        .WR_LATENCY(WL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Edge counter: after rising edge k (and before k+1) cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [LW-1:0] data;
        int            due;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      wr_q[$];
    int      checks = 0;
    int      errors = 0;

    // Reference memory: line index -> contents; absent lines read as zero.
    logic [LW-1:0] model_mem [int];

    function automatic logic [LW-1:0] model_rd(input int idx);
        if (model_mem.exists(idx)) return model_mem[idx];
        return '0;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'(a[DB+3:4]);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] idx;
        idx = 32'($urandom_range(0, 15));
        return ($urandom & 32'hFFFF_C000) | (idx << 4) | 32'($urandom_range(0, 15));
    endfunction

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completion pulse must match the oldest expectation.
    rd_exp_t mon_e;
    int      mon_due;
    always @(negedge clk) begin
        if (bus.mem_rd_data_valid === 1'b1) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got valid at cycle %0d, required no pulse", cyc);
            end else begin
                mon_e = rd_q.pop_front();
                chk("rd_data", bus.mem_rd_data, mon_e.data);
                chk("rd_cycle", LW'(cyc), LW'(mon_e.due));
            end
        end
        if (bus.mem_wr_data_ready === 1'b1) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got ready at cycle %0d, required no pulse", cyc);
            end else begin
                mon_due = wr_q.pop_front();
                chk("wr_cycle", LW'(cyc), LW'(mon_due));
            end
        end
    end

    // Bounded wait for a completion pulse (synchronisation only).
    task automatic wait_pulse(input bit is_rd, input string name);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < BUDGET) begin
            @(negedge clk);
            n++;
            seen = is_rd ? (bus.mem_rd_data_valid === 1'b1) : (bus.mem_wr_data_ready === 1'b1);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no pulse in %0d cycles, required one", name, BUDGET);
        end
    endtask

    // One transaction: write, read, or both raised together. Must be called
    // #1 after a rising edge with the responder idle; returns in that state.
    task automatic txn(input bit dw, input bit dr, input logic [31:0] wa,
                       input logic [LW-1:0] wd, input logic [31:0] ra);
        int      t0 = cyc;
        rd_exp_t e;
        bus.mem_write      = dw;
        bus.mem_write_addr = wa;
        bus.mem_wr_data    = wd;
        bus.mem_read       = dr;
        bus.mem_read_addr  = ra;
        if (dw) begin
            model_mem[line_of(wa)] = wd;
            wr_q.push_back(t0 + 1 + WL);
        end
        if (dr) begin
            e.data = model_rd(line_of(ra));
            e.due  = (dw ? t0 + 1 + WL + 2 : t0 + 1) + RL;
            rd_q.push_back(e);
        end
        // After acceptance, disturb the captured inputs of the accepted request.
        @(posedge clk) #1;
        if (dw) begin
            bus.mem_write_addr = $urandom;
            bus.mem_wr_data    = rand_line();
        end else if (dr) begin
            bus.mem_read_addr = $urandom;
        end
        if (dw) begin
            wait_pulse(1'b0, "wr");
            @(posedge clk) #1;
            bus.mem_write = 1'b0;
        end
        if (dr) begin
            wait_pulse(1'b1, "rd");
            @(posedge clk) #1;
            bus.mem_read = 1'b0;
        end
    endtask

    initial begin
        logic [LW-1:0] line_a;
        logic [LW-1:0] line_b;
        logic [LW-1:0] line_c;
        logic [LW-1:0] line_d;
        rd_exp_t       e;
        int            t0;
        int            ready_seen;

        // Reset held two cycles with a read pending.
        rst                = 1'b1;
        bus.mem_read       = 1'b1;
        bus.mem_read_addr  = 32'h0000_0300;
        bus.mem_write      = 1'b0;
        bus.mem_write_addr = '0;
        bus.mem_wr_data    = '0;
        repeat (2) begin
            @(posedge clk) #1;
            chk("rst_rd_data", bus.mem_rd_data, '0);
            chk("rst_valid", LW'(bus.mem_rd_data_valid), '0);
            chk("rst_ready", LW'(bus.mem_wr_data_ready), '0);
            chk("rst_busy", LW'(bus.busy), '0);
        end
        e.data = model_rd(line_of(32'h0000_0300));
        e.due  = cyc + 1 + RL;
        rd_q.push_back(e);
        rst = 1'b0;
        @(negedge clk);
        chk("busy_before_accept", LW'(bus.busy), '0);
        @(negedge clk);
        chk("busy_after_accept", LW'(bus.busy), 1);
        wait_pulse(1'b1, "rd_after_rst");
        @(posedge clk) #1;
        bus.mem_read = 1'b0;

        // Write then read the same line with a different byte offset.
        txn(1'b1, 1'b0, 32'h0000_0040, 128'h44444444_33333333_22222222_11111111, '0);
        txn(1'b0, 1'b1, '0, '0, 32'h0000_004C);

        // Simultaneous write and read of one line.
        line_a = rand_line();
        txn(1'b1, 1'b1, 32'h0000_0100, line_a, 32'h0000_0100);

        // Read held three cycles past its pulse: served twice.
        t0 = cyc;
        bus.mem_read      = 1'b1;
        bus.mem_read_addr = 32'h0000_004C;
        e.data = model_rd(line_of(32'h0000_004C));
        e.due  = t0 + 1 + RL;
        rd_q.push_back(e);
        e.due  = t0 + 1 + RL + 2 + RL;
        rd_q.push_back(e);
        wait_pulse(1'b1, "held_rd1");
        repeat (3) @(posedge clk) #1;
        bus.mem_read = 1'b0;
        wait_pulse(1'b1, "held_rd2");
        @(posedge clk) #1;

        // Address wrap modulo the store size.
        line_b = rand_line();
        txn(1'b1, 1'b0, 32'h0000_4010, line_b, '0);
        txn(1'b0, 1'b1, '0, '0, 32'h0000_0010);

        // Reset during a write with one count left: write aborted.
        line_d = rand_line();
        line_c = ~line_d;
        txn(1'b1, 1'b0, 32'h0000_0200, line_d, '0);
        bus.mem_write      = 1'b1;
        bus.mem_write_addr = 32'h0000_0200;
        bus.mem_wr_data    = line_c;
        repeat (3) @(posedge clk) #1;
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        bus.mem_write = 1'b0;
        chk("abort_busy", LW'(bus.busy), '0);
        ready_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.mem_wr_data_ready === 1'b1) ready_seen++;
        end
        chk("abort_no_ready", LW'(ready_seen), '0);
        @(posedge clk) #1;
        txn(1'b0, 1'b1, '0, '0, 32'h0000_0200);

        // Randomised mix of writes, reads and simultaneous requests.
        for (int i = 0; i < 40; i++) begin
            int            kind;
            logic [31:0]   wa;
            logic [31:0]   ra;
            kind = $urandom_range(0, 2);
            wa   = rand_addr();
            ra   = ($urandom_range(0, 1) == 1) ? (wa ^ 32'h0000_4005) : rand_addr();
            case (kind)
                0:       txn(1'b1, 1'b0, wa, rand_line(), ra);
                1:       txn(1'b0, 1'b1, wa, '0, ra);
                default: txn(1'b1, 1'b1, wa, rand_line(), ra);
            endcase
        end

        repeat (5) @(posedge clk);
        chk("rd_queue_drained", LW'(rd_q.size()), '0);
        chk("wr_queue_drained", LW'(wr_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
